// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: steps an 8-bit ALU through a chain of len_i+1 bytes and folds the per-byte flags.
// Optional feature macro: ALU_SEQ_CARRYIN_EN (adds carry_i and a carried first byte for ADD/SUB/SLL/SRL).
module alu_seq #(
    parameter int LENW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef ALU_SEQ_CARRYIN_EN
    input  logic            carry_i,
`endif
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [LENW-1:0] len_i,
    input  logic            gnt_i,
    output logic            req_o,
    output logic [5:0]      aluinst_o,
    output logic            c_alu_o,
    output logic [LENW-1:0] idx_o,
    output logic            we_o,
    input  logic            c_alu_i,
    input  logic            z_alu_i,
    input  logic            n_alu_i,
    input  logic            o_alu_i,
    output logic            c_o,
    output logic            z_o,
    output logic            n_o,
    output logic            o_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [5:0] {
        ALUINST_PASS0 = 6'h00,
        ALUINST_ADD   = 6'h01,
        ALUINST_ADC   = 6'h02,
        ALUINST_SUB   = 6'h03,
        ALUINST_SBC   = 6'h04,
        ALUINST_AND   = 6'h05,
        ALUINST_OR    = 6'h06,
        ALUINST_XOR   = 6'h07,
        ALUINST_SLL   = 6'h08,
        ALUINST_RLC   = 6'h09,
        ALUINST_SRL   = 6'h0A,
        ALUINST_RRC   = 6'h0B
    } aluinst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] idx_q, idx_d;
    logic            first_q, first_d;
    logic            carry_q, carry_d;
    logic            zacc_q, zacc_d;
    logic            par_q, par_d;
    logic            nlen_q, nlen_d;
    logic            olen_q, olen_d;
    logic            c_q, c_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            o_q, o_d;

    logic            start_carry;
    logic            plain_first;
    aluinst_t        run_inst;
    logic            at_len, last_byte, arith;
    logic            z_fin, par_fin, n_fin, olen_fin;

    // With carry-in enabled every arithmetic/shift byte is a carried one, seeded from carry_i.
`ifdef ALU_SEQ_CARRYIN_EN
    assign start_carry = carry_i;
    assign plain_first = 1'b0;
`else
    assign start_carry = 1'b0;
    assign plain_first = first_q;
`endif

    assign at_len    = (idx_q == len_q);
    assign last_byte = (op_q == OP_SRL) ? (idx_q == '0) : at_len;
    assign arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign z_fin     = zacc_q & z_alu_i;
    assign par_fin   = par_q ^ o_alu_i;
    assign n_fin     = at_len ? n_alu_i : nlen_q;
    assign olen_fin  = at_len ? o_alu_i : olen_q;

    always_comb begin
        run_inst = ALUINST_ADD;
        case (op_q)
            OP_ADD:  run_inst = plain_first ? ALUINST_ADD : ALUINST_ADC;
            OP_SUB:  run_inst = plain_first ? ALUINST_SUB : ALUINST_SBC;
            OP_AND:  run_inst = ALUINST_AND;
            OP_OR:   run_inst = ALUINST_OR;
            OP_XOR:  run_inst = ALUINST_XOR;
            OP_SLL:  run_inst = plain_first ? ALUINST_SLL : ALUINST_RLC;
            OP_SRL:  run_inst = plain_first ? ALUINST_SRL : ALUINST_RRC;
            default: run_inst = plain_first ? ALUINST_ADD : ALUINST_ADC;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        len_d     = len_q;
        idx_d     = idx_q;
        first_d   = first_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        par_d     = par_q;
        nlen_d    = nlen_q;
        olen_d    = olen_q;
        c_d       = c_q;
        z_d       = z_q;
        n_d       = n_q;
        o_d       = o_q;
        req_o     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        we_o      = 1'b0;
        idx_o     = '0;
        c_alu_o   = 1'b0;
        aluinst_o = ALUINST_PASS0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    // Reserved opcode 7 is folded into ADD once, at latch time.
                    op_d    = (op_i == 3'd7) ? OP_ADD : op_i;
                    len_d   = len_i;
                    idx_d   = (op_i == OP_SRL) ? len_i : '0;
                    first_d = 1'b1;
                    carry_d = start_carry;
                    zacc_d  = 1'b1;
                    par_d   = 1'b0;
                    nlen_d  = 1'b0;
                    olen_d  = 1'b0;
                end
            end
            ST_RUN: begin
                req_o     = 1'b1;
                busy_o    = 1'b1;
                we_o      = gnt_i;
                idx_o     = idx_q;
                c_alu_o   = carry_q;
                aluinst_o = run_inst;
                if (gnt_i) begin
                    first_d = 1'b0;
                    carry_d = c_alu_i;
                    zacc_d  = z_fin;
                    par_d   = par_fin;
                    nlen_d  = n_fin;
                    olen_d  = olen_fin;
                    if (last_byte) begin
                        state_d = ST_DONE;
                        c_d     = c_alu_i;
                        z_d     = z_fin;
                        n_d     = n_fin;
                        o_d     = arith ? olen_fin : par_fin;
                    end else if (op_q == OP_SRL) begin
                        idx_d = idx_q - LENW'(1);
                    end else begin
                        idx_d = idx_q + LENW'(1);
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            len_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            par_q   <= 1'b0;
            nlen_q  <= 1'b0;
            olen_q  <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            par_q   <= par_d;
            nlen_q  <= nlen_d;
            olen_q  <= olen_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            o_q     <= o_d;
        end
    end

    assign c_o = c_q;
    assign z_o = z_q;
    assign n_o = n_q;
    assign o_o = o_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a byte-ALU model answers the DUT, a whole-word arithmetic model predicts the chain result.
module tb_alu_seq;
    localparam int LENW = 3;

    localparam logic [5:0] I_PASS0 = 6'h00, I_ADD = 6'h01, I_ADC = 6'h02, I_SUB = 6'h03;
    localparam logic [5:0] I_SBC = 6'h04, I_AND = 6'h05, I_OR = 6'h06, I_XOR = 6'h07;
    localparam logic [5:0] I_SLL = 6'h08, I_RLC = 6'h09, I_SRL = 6'h0A, I_RRC = 6'h0B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic [2:0] op_i = '0;
    logic [LENW-1:0] len_i = '0;
    logic gnt_i = 1'b1;
`ifdef ALU_SEQ_CARRYIN_EN
    logic carry_i = 1'b0;
`endif
    logic req_o, c_alu_o, we_o, c_o, z_o, n_o, o_o, busy_o, done_o;
    logic [5:0] aluinst_o;
    logic [LENW-1:0] idx_o;
    logic c_alu_i, z_alu_i, n_alu_i, o_alu_i;

    always #5 clk = ~clk;

    alu_seq #(.LENW(LENW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_SEQ_CARRYIN_EN
        .carry_i(carry_i),
`endif
        .start_i(start_i), .op_i(op_i), .len_i(len_i), .gnt_i(gnt_i),
        .req_o(req_o), .aluinst_o(aluinst_o), .c_alu_o(c_alu_o), .idx_o(idx_o), .we_o(we_o),
        .c_alu_i(c_alu_i), .z_alu_i(z_alu_i), .n_alu_i(n_alu_i), .o_alu_i(o_alu_i),
        .c_o(c_o), .z_o(z_o), .n_o(n_o), .o_o(o_o), .busy_o(busy_o), .done_o(done_o)
    );

    // Byte-wide ALU the sequencer drives; SUB/SBC carry means "no borrow".
    logic [63:0] a_vec = '0, b_vec = '0;
    logic [7:0]  alu_a, alu_b, alu_r;
    logic [8:0]  alu_s;
    always_comb begin
        alu_a   = a_vec[8*int'(idx_o) +: 8];
        alu_b   = b_vec[8*int'(idx_o) +: 8];
        alu_s   = '0;
        alu_r   = alu_a;
        c_alu_i = 1'b0;
        o_alu_i = 1'b0;
        case (aluinst_o)
            I_ADD, I_ADC: begin
                alu_s   = {1'b0, alu_a} + {1'b0, alu_b} + 9'((aluinst_o == I_ADC) ? c_alu_o : 1'b0);
                alu_r   = alu_s[7:0];
                c_alu_i = alu_s[8];
                o_alu_i = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
            end
            I_SUB, I_SBC: begin
                alu_s   = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'((aluinst_o == I_SBC) ? c_alu_o : 1'b1);
                alu_r   = alu_s[7:0];
                c_alu_i = alu_s[8];
                o_alu_i = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
            end
            I_AND: begin alu_r = alu_a & alu_b; o_alu_i = ^alu_r; end
            I_OR:  begin alu_r = alu_a | alu_b; o_alu_i = ^alu_r; end
            I_XOR: begin alu_r = alu_a ^ alu_b; o_alu_i = ^alu_r; end
            I_SLL, I_RLC: begin
                alu_r   = {alu_a[6:0], (aluinst_o == I_RLC) ? c_alu_o : 1'b0};
                c_alu_i = alu_a[7];
                o_alu_i = ^alu_r;
            end
            I_SRL, I_RRC: begin
                alu_r   = {(aluinst_o == I_RRC) ? c_alu_o : 1'b0, alu_a[7:1]};
                c_alu_i = alu_a[0];
                o_alu_i = ^alu_r;
            end
            default: alu_r = alu_a;
        endcase
        z_alu_i = (alu_r == 8'd0);
        n_alu_i = alu_r[7];
    end

    typedef struct {
        logic [63:0] r;
        logic        c, z, n, o;
        int          nb;
        int          start_cyc;
        int          lat;
    } txn_t;
    typedef struct {
        int         idx;
        logic [5:0] inst;
    } beat_t;

    txn_t  exp_q[$];
    beat_t beat_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: per-cycle protocol checks, per-beat order checks, per-completion result checks.
    logic [63:0] res_vec = '0;
    int          stalls = 0;
    bit          prev_stall = 1'b0;
    logic [LENW-1:0] prev_idx = '0;
    logic [5:0]  prev_inst = '0;
    always @(negedge clk) begin
        beat_t b;
        txn_t  t;
        logic [63:0] m;
        chk(req_o == busy_o, "req_eq_busy", 64'(req_o), 64'(busy_o));
        chk(we_o == (busy_o && gnt_i), "we_strobe", 64'(we_o), 64'(busy_o && gnt_i));
        if (!busy_o) begin
            chk(aluinst_o == I_PASS0 && idx_o == '0, "idle_outs", {aluinst_o, 8'(idx_o)}, 64'(I_PASS0) << 8);
        end
        if (busy_o && prev_stall) begin
            chk(idx_o == prev_idx && aluinst_o == prev_inst, "stall_hold", {aluinst_o, 8'(idx_o)}, {prev_inst, 8'(prev_idx)});
        end
        prev_stall = busy_o && !gnt_i;
        prev_idx   = idx_o;
        prev_inst  = aluinst_o;
        if (busy_o && !gnt_i) stalls++;
        if (we_o) begin
            if (beat_q.size() == 0) begin
                chk(1'b0, "beat_unexpected", {aluinst_o, 8'(idx_o)}, 64'd0);
            end else begin
                b = beat_q.pop_front();
                chk(int'(idx_o) == b.idx, "beat_idx", 64'(idx_o), 64'(b.idx));
                chk(aluinst_o == b.inst, "beat_inst", 64'(aluinst_o), 64'(b.inst));
            end
            res_vec[8*int'(idx_o) +: 8] = alu_r;
        end
        if (done_o) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "done_unexpected", 64'(done_o), 64'd0);
            end else begin
                t = exp_q.pop_front();
                m = (t.nb >= 64) ? '1 : ((64'd1 << t.nb) - 64'd1);
                chk((res_vec & m) == t.r, "result", res_vec & m, t.r);
                chk({c_o, z_o, n_o, o_o} == {t.c, t.z, t.n, t.o}, "flags_czno",
                    64'({c_o, z_o, n_o, o_o}), 64'({t.c, t.z, t.n, t.o}));
                chk(cyc - t.start_cyc - stalls == t.lat, "latency", 64'(cyc - t.start_cyc - stalls), 64'(t.lat));
            end
        end
        if (!busy_o) begin
            stalls  = 0;
            res_vec = '0;
        end
    end

    function automatic logic [5:0] exp_inst(input logic [2:0] op, input bit first);
        case (op)
            3'd0: return first ? I_ADD : I_ADC;
            3'd1: return first ? I_SUB : I_SBC;
            3'd2: return I_AND;
            3'd3: return I_OR;
            3'd4: return I_XOR;
            3'd5: return first ? I_SLL : I_RLC;
            3'd6: return first ? I_SRL : I_RRC;
            default: return first ? I_ADD : I_ADC;
        endcase
    endfunction

    // Predict the whole chain as one wide word and queue expectations. Call at posedge+#1.
    task automatic issue(input logic [2:0] op, input int len, input logic [63:0] a, input logic [63:0] b);
        txn_t t;
        beat_t bt;
        logic [2:0] eop;
        logic [71:0] mask, av, bv, s, r;
        bit cin0, plain_first;
        int nb;
        eop  = (op == 3'd7) ? 3'd0 : op;
        nb   = (len + 1) * 8;
        mask = (72'd1 << nb) - 72'd1;
        av   = {8'd0, a} & mask;
        bv   = {8'd0, b} & mask;
        cin0 = (eop == 3'd1);
        plain_first = 1'b1;
`ifdef ALU_SEQ_CARRYIN_EN
        carry_i = 1'($urandom_range(0, 1));
        plain_first = 1'b0;
        if (eop == 3'd0 || eop == 3'd1 || eop == 3'd5 || eop == 3'd6) cin0 = carry_i;
`endif
        s = '0;
        t.c = 1'b0;
        t.o = 1'b0;
        case (eop)
            3'd0: begin
                s = av + bv + 72'(cin0); r = s & mask; t.c = s[nb];
                t.o = (av[nb-1] == bv[nb-1]) && (r[nb-1] != av[nb-1]);
            end
            3'd1: begin
                s = av + (~bv & mask) + 72'(cin0); r = s & mask; t.c = s[nb];
                t.o = (av[nb-1] != bv[nb-1]) && (r[nb-1] != av[nb-1]);
            end
            3'd2: begin r = av & bv; t.o = ^r; end
            3'd3: begin r = av | bv; t.o = ^r; end
            3'd4: begin r = av ^ bv; t.o = ^r; end
            3'd5: begin r = ((av << 1) | 72'(cin0)) & mask; t.c = av[nb-1]; t.o = ^r; end
            default: begin r = (av >> 1) | (72'(cin0) << (nb - 1)); t.c = av[0]; t.o = ^r; end
        endcase
        t.r = r[63:0];
        t.z = (r == '0);
        t.n = r[nb-1];
        t.nb = nb;
        t.start_cyc = cyc;
        t.lat = len + 2;
        for (int k = 0; k <= len; k++) begin
            bt.idx  = (eop == 3'd6) ? (len - k) : k;
            bt.inst = exp_inst(eop, plain_first && (k == 0));
            beat_q.push_back(bt);
        end
        exp_q.push_back(t);
        a_vec   = a;
        b_vec   = b;
        op_i    = op;
        len_i   = LENW'(len);
        start_i = 1'b1;
    endtask

    // gmode: 0 grant always, 1 random grant, 2 grant low on the 2nd and 3rd RUN cycles.
    task automatic run_txn(input logic [2:0] op, input int len, input logic [63:0] a, input logic [63:0] b, input int gmode);
        int t;
        issue(op, len, a, b);
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (!done_o && t < 200) begin
            case (gmode)
                0: gnt_i = 1'b1;
                1: gnt_i = ($urandom_range(0, 3) != 0);
                default: gnt_i = !(t == 1 || t == 2);
            endcase
            op_i    = 3'($urandom);
            len_i   = LENW'($urandom);
            start_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        start_i = 1'b0;
        gnt_i   = 1'b1;
        chk(done_o, "done_timeout", 64'(done_o), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk({busy_o, done_o, req_o, we_o} == 4'b0, "reset_ctrl", 64'({busy_o, done_o, req_o, we_o}), 64'd0);
        chk({c_o, z_o, n_o, o_o} == 4'b0, "reset_flags", 64'({c_o, z_o, n_o, o_o}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(3'd0, 1, 64'h00FF, 64'h0001, 0);
        run_txn(3'd1, 1, 64'h0001, 64'h0001, 0);
        run_txn(3'd6, 2, 64'h814203, 64'h0, 0);
        run_txn(3'd0, 3, 64'h7FFF_FFFF, 64'h0000_0001, 2);
        run_txn(3'd7, 0, 64'h80, 64'h80, 0);

        // Reset mid-chain: no completion, flags cleared, next start restarts at idx 0.
        issue(3'd0, 3, 64'h1234_5678, 64'h0F0F_0F0F);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(idx_o == LENW'(2), "midreset_idx", 64'(idx_o), 64'd2);
        rst_n = 1'b0;
        #1;
        chk({busy_o, req_o, we_o, done_o} == 4'b0, "midreset_ctrl", 64'({busy_o, req_o, we_o, done_o}), 64'd0);
        chk({c_o, z_o, n_o, o_o} == 4'b0, "midreset_flags", 64'({c_o, z_o, n_o, o_o}), 64'd0);
        exp_q.delete();
        beat_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk(!done_o, "midreset_nodone", 64'(done_o), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(3'd0, 3, 64'hFFFF_FFFF, 64'h0000_0001, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(3'($urandom), $urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom}, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk(exp_q.size() == 0 && beat_q.size() == 0, "queues_drained", 64'(exp_q.size() + beat_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter LENW, default 3, width of len_i; chain length is len_i+1 bytes, max 2^LENW.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request a multi-byte operation; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 reserved (treated as ADD).
REQ-006 SHALL have port len_i  input  LENW  byte count minus one.
REQ-007 SHALL have port gnt_i  input  1  ALU granted to sequencer this cycle.
REQ-008 SHALL have port req_o  output  1  ALU requested; high whenever busy_o is high.
REQ-009 SHALL have port aluinst_o  output  6  aluinst_t encoding driven to the ALU.
REQ-010 SHALL have port c_alu_o  output  1  carry-in to ALU.
REQ-011 SHALL have port idx_o  output  LENW  byte index of current operand/result.
REQ-012 SHALL have port we_o  output  1  result byte write strobe (req_o && gnt_i).
REQ-013 SHALL have ports c_alu_i, z_alu_i, n_alu_i, o_alu_i  input  1 each  ALU flag outputs for the current byte.
REQ-014 SHALL have ports c_o, z_o, n_o, o_o  output  1 each  final chain flags.
REQ-015 SHALL have ports busy_o  output  1, and done_o  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start_i, RUN->DONE after last byte issued with gnt_i, DONE->IDLE unconditionally next cycle.
REQ-017 SHALL latch op_i and len_i on IDLE->RUN; later changes ignored until IDLE; start_i outside IDLE ignored.
REQ-018 SHALL issue one byte per cycle when gnt_i=1; gnt_i=0 holds idx_o, aluinst_o, c_alu_o and accumulated flags unchanged, we_o=0.
REQ-019 SHALL order bytes ascending (idx 0..len) for all ops except SRL, which runs descending (len..0).
REQ-020 SHALL issue first byte ADD/SUB/SLL/SRL then ADC/SBC/RLC/RRC for subsequent bytes; logic ops issue AND/OR/XOR every byte.
REQ-021 SHALL register c_alu_i on each granted byte and drive it on c_alu_o for the next byte; first byte c_alu_o=0.
REQ-022 SHALL set z_o = AND of z_alu_i over all bytes; n_o = n_alu_i of byte idx=len; c_o = c_alu_i of last issued byte.
REQ-023 SHALL set o_o = o_alu_i of byte idx=len for ADD/SUB, and XOR of o_alu_i over all bytes (chain parity) for logic and shift ops.
REQ-024 SHALL update c_o/z_o/n_o/o_o only on RUN->DONE; they hold until next completion.
REQ-025 SHALL assert done_o exactly in DONE; busy_o high in RUN only; latency = len+2 cycles from start_i to done_o with gnt_i held high.
REQ-026 SHALL drive aluinst_o=ALUINST_PASS0, we_o=0, idx_o=0 in IDLE and DONE.

Reset
REQ-027 SHALL on rst_n low immediately enter IDLE, clear idx, carry register, accumulators, c_o/z_o/n_o/o_o=0, busy_o/done_o/req_o/we_o=0, including mid-operation (no done_o).

Configuration
REQ-028 SHALL with ALU_SEQ_CARRYIN_EN defined add port carry_i input 1, issue first byte of ADD/SUB/SLL/SRL as ADC/SBC/RLC/RRC with c_alu_o=carry_i latched at start (for chains beyond 2^LENW); without it, no carry_i port and REQ-020/021 first-byte behaviour applies.

Verification
REQ-029 SHALL cover ADD len=1, bytes 0x00FF+0x0001, gnt_i=1 -> aluinst ADD,ADC; idx 0,1; done_o at cycle 3; c_o=0, z_o=0, n_o=0.
REQ-030 SHALL cover SUB len=1, 0x0001-0x0001 -> SUB,SBC; z_o=1, c_o=1 (no borrow), o_o=0.
REQ-031 SHALL cover SRL len=2 -> idx order 2,1,0; aluinst SRL,RRC,RRC; c_o = bit0 of byte 0.
REQ-032 SHALL cover ADD len=3 with gnt_i low on cycles 2-3 -> idx/aluinst frozen, we_o=0, done_o delayed 2 cycles, result identical.
REQ-033 SHALL cover rst_n low during RUN idx=2 -> busy_o=0 immediately, no done_o, subsequent start_i runs cleanly from idx 0.
REQ-034 SHALL cover, with ALU_SEQ_CARRYIN_EN, ADD len=0 carry_i=1, 0xFF+0x00 -> aluinst ADC, c_alu_o=1, c_o=1, z_o=1.
